// File: rtl/aes_sub_shift_engine.sv
// Iterative AES SubBytes + ShiftRows engine, LANES S-box lookups per cycle.
// Define AES_SUBSHIFT_INV_EN to add inv_mode (InvSubBytes + InvShiftRows).
`timescale 1ns/1ps
module aes_sub_shift_engine #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
`ifdef AES_SUBSHIFT_INV_EN
  input  logic         inv_mode,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int unsigned NGRP = 16 / LANES;
  localparam int unsigned CW   = (NGRP > 1) ? $clog2(NGRP) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_check
    $error("aes_sub_shift_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a12, a15, a240;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a12  = gf_mul(gf_mul(a3, a3), gf_mul(a3, a3));
    a15  = gf_mul(a12, a3);
    a240 = gf_mul(a15, a15);
    a240 = gf_mul(a240, a240);
    a240 = gf_mul(a240, a240);
    a240 = gf_mul(a240, a240);
    return gf_mul(gf_mul(a240, a12), a2);
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
    logic [7:0] i;
    i = gf_inv(b);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

`ifdef AES_SUBSHIFT_INV_EN
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_inv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
  endfunction
`endif

  // Byte k = 4c + r; forward moves column c to c - r, inverse to c + r.
  function automatic logic [3:0] dest_idx(input logic [3:0] k, input logic inv);
    logic [1:0] cd;
    cd = inv ? (k[3:2] + k[1:0]) : (k[3:2] - k[1:0]);
    return {cd, k[1:0]};
  endfunction

  typedef enum logic [1:0] {StIdle, StSub, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] grp_q;
  logic [7:0]    src_q [16];
  logic [7:0]    res_q [16];
  logic [7:0]    res_d [16];
  logic [7:0]    lane_out [LANES];
  logic [3:0]    lane_idx [LANES];
  logic          accept, last_grp, inv_q;

  assign accept   = in_valid && in_ready;
  assign last_grp = (grp_q == CW'(NGRP - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StSub;
      StSub:   if (last_grp) state_d = StDone;
      StDone:  if (out_ready) state_d = in_valid ? StSub : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle) || (state_q == StDone && out_ready);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
  end

`ifdef AES_SUBSHIFT_INV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      inv_q <= 1'b0;
    else if (accept) inv_q <= inv_mode;
  end
`else
  assign inv_q = 1'b0;
`endif

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = 4'(int'(grp_q) * LANES + l);
`ifdef AES_SUBSHIFT_INV_EN
      lane_out[l] = inv_q ? inv_sbox(src_q[lane_idx[l]]) : fwd_sbox(src_q[lane_idx[l]]);
`else
      lane_out[l] = fwd_sbox(src_q[lane_idx[l]]);
`endif
    end
  end

  always_comb begin
    res_d = res_q;
    if (state_q == StSub) begin
      for (int l = 0; l < LANES; l++) res_d[dest_idx(lane_idx[l], inv_q)] = lane_out[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_q <= '0;
      for (int i = 0; i < 16; i++) begin
        src_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        grp_q <= '0;
        for (int i = 0; i < 16; i++) src_q[i] <= in_state[127 - 8*i -: 8];
      end else if (state_q == StSub && !last_grp) begin
        grp_q <= grp_q + 1'b1;
      end
      for (int i = 0; i < 16; i++) res_q[i] <= res_d[i];
    end
  end

  always_comb begin
    out_state = '0;
    for (int i = 0; i < 16; i++) out_state[127 - 8*i -: 8] = res_q[i];
  end

endmodule

// File: tb/tb_aes_sub_shift_engine.sv
// Directed bench: main DUT with LANES=4, plus LANES=1 and LANES=16 instances for latency.
`timescale 1ns/1ps
module tb_aes_sub_shift_engine;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, out_ready;
  logic [127:0] in_state;
  logic         inv_mode;
  logic         in_ready1, out_valid1, busy1;
  logic         in_ready4, out_valid4, busy4;
  logic         in_ready16, out_valid16, busy16;
  logic [127:0] out_state1, out_state4, out_state16;

  always #5 clk = ~clk;

  aes_sub_shift_engine #(.LANES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .in_state(in_state),
`ifdef AES_SUBSHIFT_INV_EN
    .inv_mode(inv_mode),
`endif
    .out_valid(out_valid4), .out_ready(out_ready), .out_state(out_state4), .busy(busy4)
  );

  aes_sub_shift_engine #(.LANES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_state(in_state),
`ifdef AES_SUBSHIFT_INV_EN
    .inv_mode(inv_mode),
`endif
    .out_valid(out_valid1), .out_ready(out_ready), .out_state(out_state1), .busy(busy1)
  );

  aes_sub_shift_engine #(.LANES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16), .in_state(in_state),
`ifdef AES_SUBSHIFT_INV_EN
    .inv_mode(inv_mode),
`endif
    .out_valid(out_valid16), .out_ready(out_ready), .out_state(out_state16), .busy(busy16)
  );

  int           n_checks = 0;
  int           n_pass   = 0;
  logic [2047:0] sbox_tbl;

  localparam logic [127:0] AppBIn  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] AppBOut = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] fsb(input logic [7:0] x);
    return sbox_tbl[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [127:0] ref_ss(input logic [127:0] s);
    logic [127:0] o;
    int r, c, d;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      r = k % 4;
      c = k / 4;
      d = 4 * ((c - r + 4) % 4) + r;
      o[127 - 8*d -: 8] = fsb(s[127 - 8*k -: 8]);
    end
    return o;
  endfunction

  task automatic accept_blk(input string tag, input logic [127:0] blk);
    in_state = blk;
    in_valid = 1'b1;
    #1;
    check({tag, "_in_ready"}, 128'(in_ready4), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_out(input string tag, input logic [127:0] exp);
    int n = 0;
    while (!out_valid4 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'(4));
    check({tag, "_data"}, out_state4, exp);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [127:0] blks [8];
    logic [127:0] held;
    int lat1, lat4, lat16, sent, rcv, cyc, last_cyc;
    logic acc, done;

    sbox_tbl = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_state = '0; inv_mode = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_out_valid", 128'({out_valid1, out_valid4, out_valid16}), 128'(0));
    check("rst_busy", 128'(busy4), 128'(0));
    check("rst_out_state", out_state4, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 128'(in_ready4), 128'(1));

    // All-zero block on all three lane widths; count edges to out_valid.
    in_state = '0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("sub_in_ready", 128'(in_ready4), 128'(0));
    check("sub_busy", 128'(busy4), 128'(1));
    lat1 = 0; lat4 = 0; lat16 = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (out_valid1 && lat1 == 0) lat1 = n;
      if (out_valid4 && lat4 == 0) lat4 = n;
      if (out_valid16 && lat16 == 0) lat16 = n;
    end
    check("zero_lat_l1", 128'(lat1), 128'(16));
    check("zero_lat_l4", 128'(lat4), 128'(4));
    check("zero_lat_l16", 128'(lat16), 128'(1));
    check("zero_data_l1", out_state1, {16{8'h63}});
    check("zero_data_l4", out_state4, {16{8'h63}});
    check("zero_data_l16", out_state16, {16{8'h63}});
    drain();
    check("drain_out_valid", 128'({out_valid1, out_valid4, out_valid16}), 128'(0));
    check("drain_in_ready", 128'({in_ready1, in_ready4, in_ready16}), 128'(7));
    check("drain_busy", 128'({busy1, busy4, busy16}), 128'(0));

    accept_blk("appb", AppBIn);
    wait_out("appb", AppBOut);

    // Backpressure: result must hold while out_ready stays low.
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      in_state = {$urandom, $urandom, $urandom, $urandom};
      check("bp_data", out_state4, AppBOut);
      check("bp_flags", 128'({in_ready4, out_valid4}), 128'(1));
    end
    held = 128'h00112233445566778899aabbccddeeff;
    out_ready = 1'b1;
    accept_blk("b2b", held);
    out_ready = 1'b0;
    check("b2b_out_valid", 128'(out_valid4), 128'(0));
    wait_out("b2b", ref_ss(held));

    // Reset during the second SUB cycle aborts the block.
    drain();
    accept_blk("abort", 128'hffeeddccbbaa99887766554433221100);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 128'(out_valid4), 128'(0));
    check("abort_busy", 128'(busy4), 128'(0));
    check("abort_out_state", out_state4, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    held = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    accept_blk("post_rst", held);
    wait_out("post_rst", ref_ss(held));
    drain();

    // Streaming with both handshakes held high.
    for (int i = 0; i < 8; i++) blks[i] = {$urandom, $urandom, $urandom, $urandom};
    sent = 0; rcv = 0; cyc = 0; last_cyc = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_state = blks[0];
    while (rcv < 8 && cyc < 200) begin
      acc  = in_valid && in_ready4;
      done = out_valid4 && out_ready;
      if (done) begin
        check("stream_data", out_state4, ref_ss(blks[rcv]));
        if (rcv > 0) check("stream_period", 128'(cyc - last_cyc), 128'(5));
        last_cyc = cyc;
        rcv++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        if (sent < 8) in_state = blks[sent];
        else in_valid = 1'b0;
      end
    end
    check("stream_count", 128'(rcv), 128'(8));
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;

`ifdef AES_SUBSHIFT_INV_EN
    inv_mode = 1'b1;
    accept_blk("inv", AppBOut);
    inv_mode = 1'b0;
    wait_out("inv", AppBIn);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
